// File: rtl/enigma_pkg.sv
// Shared types and modular helpers for the sequential enigma core.
package enigma_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_STEP, S_FWD, S_REFL, S_BWD, S_DONE
  } state_t;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  // Operands are IW-wide indices already reduced below the modulus.
  function automatic int unsigned add_mod(input int unsigned a, input int unsigned b,
                                          input int unsigned m);
    int unsigned s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

  function automatic int unsigned sub_mod(input int unsigned a, input int unsigned b,
                                          input int unsigned m);
    return (a >= b) ? a - b : a + m - b;
  endfunction

endpackage

// File: rtl/enigma_if.sv
// Character handshake between the I/O front end and the enigma core.
interface enigma_if;
  logic       valid;
  logic       ready;
  logic [7:0] din;
  logic [7:0] dout;
  logic       done;

  modport master (output valid, din, input ready, dout, done);
  modport slave  (input valid, din, output ready, dout, done);
endinterface

// File: rtl/enigma_lut.sv
// Shared rotor lookup: forward map or lowest-index inverse search of one selected rotor.
module enigma_lut
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int IW         = $clog2(ALPHA),
  parameter int SW         = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1
) (
  input  logic [NUM_ROTORS*ALPHA*IW-1:0] map_bus,
  input  logic [SW-1:0]                  sel,
  input  logic [IW-1:0]                  operand,
  input  logic [IW-1:0]                  pos,
  input  logic                           dir,
  output logic [IW-1:0]                  result
);

  int unsigned idx, fv, iv;

  always_comb begin
    idx = add_mod(32'(operand), 32'(pos), ALPHA);
    fv  = 32'(map_bus[(32'(sel)*ALPHA + idx)*IW +: IW]) % ALPHA;
    // Descending scan so the lowest matching index wins; no match leaves 0.
    iv  = 0;
    for (int j = ALPHA-1; j >= 0; j--) begin
      if (32'(map_bus[(32'(sel)*ALPHA + 32'(j))*IW +: IW]) % ALPHA == idx)
        iv = 32'(j);
    end
    result = IW'(sub_mod(dir ? iv : fv, 32'(pos), ALPHA));
  end

endmodule

// File: rtl/enigma_core.sv
// Sequential enigma: one shared lookup walked through N forward, reflector, N backward stages.
// Optional plugboard enabled by defining ENIGMA_PLUGBOARD_EN.
module enigma_core
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter int ALPHA      = 26,
  parameter int IW         = $clog2(ALPHA)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           set,
  input  logic                           en,
  input  logic [NUM_ROTORS*IW-1:0]       pos_in,
  input  logic [NUM_ROTORS*ALPHA*IW-1:0] wiring_in,
  input  logic [ALPHA*IW-1:0]            refl_in,
`ifdef ENIGMA_PLUGBOARD_EN
  input  logic [ALPHA*IW-1:0]            plug_in,
`endif
  output logic [NUM_ROTORS*IW-1:0]       pos_out,
  enigma_if.slave                        io
);

  localparam int SW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;

  state_t                         state;
  logic [SW-1:0]                  k;
  logic [IW-1:0]                  x;
  logic [NUM_ROTORS-1:0][IW-1:0]  pos_q, pos_step;
  logic [NUM_ROTORS*ALPHA*IW-1:0] wiring_q;
  logic [ALPHA*IW-1:0]            refl_q;
  logic [7:0]                     dout_q;
  logic                           done_q;
  logic [IW-1:0]                  lut_x, refl_x;
  logic [7:0]                     din_off;
  logic                           is_letter, carry;

`ifdef ENIGMA_PLUGBOARD_EN
  logic [ALPHA*IW-1:0] plug_q;

  function automatic logic [ALPHA*IW-1:0] ident_map();
    logic [ALPHA*IW-1:0] m;
    m = '0;
    for (int j = 0; j < ALPHA; j++) m[j*IW +: IW] = IW'(j);
    return m;
  endfunction

  function automatic logic [IW-1:0] plug_map(input logic [IW-1:0] v);
    return IW'(32'(plug_q[32'(v)*IW +: IW]) % ALPHA);
  endfunction
`else
  function automatic logic [IW-1:0] plug_map(input logic [IW-1:0] v);
    return v;
  endfunction
`endif

  assign pos_out  = pos_q;
  assign io.ready = reset_n && (state == S_IDLE);
  assign io.dout  = dout_q;
  assign io.done  = done_q;

  assign din_off   = io.din - ASCII_A;
  assign is_letter = (io.din >= ASCII_A) && (io.din <= ASCII_Z);
  assign refl_x    = IW'(32'(refl_q[32'(x)*IW +: IW]) % ALPHA);

  // Odometer: each rotor advances only while the carry from below is still live.
  always_comb begin
    pos_step = pos_q;
    carry    = 1'b1;
    for (int r = 0; r < NUM_ROTORS; r++) begin
      if (carry) begin
        if (pos_q[r] == IW'(ALPHA-1)) pos_step[r] = '0;
        else begin
          pos_step[r] = pos_q[r] + 1'b1;
          carry       = 1'b0;
        end
      end
    end
  end

  enigma_lut #(.NUM_ROTORS(NUM_ROTORS), .ALPHA(ALPHA), .IW(IW), .SW(SW)) u_lut (
    .map_bus (wiring_q),
    .sel     (k),
    .operand (x),
    .pos     (pos_q[k]),
    .dir     (state == S_BWD),
    .result  (lut_x)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      k        <= '0;
      x        <= '0;
      pos_q    <= '0;
      wiring_q <= '0;
      refl_q   <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_q   <= ident_map();
`endif
    end else if (set) begin
      state    <= S_IDLE;
      k        <= '0;
      pos_q    <= pos_in;
      wiring_q <= wiring_in;
      refl_q   <= refl_in;
      dout_q   <= '0;
      done_q   <= 1'b0;
`ifdef ENIGMA_PLUGBOARD_EN
      plug_q   <= plug_in;
`endif
    end else if (en) begin
      case (state)
        S_IDLE: if (io.valid) begin
          if (is_letter) begin
            x     <= plug_map(IW'(din_off));
            state <= S_STEP;
          end else begin
            dout_q <= io.din;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_STEP: begin
          pos_q <= pos_step;
          k     <= '0;
          state <= S_FWD;
        end
        S_FWD: begin
          x <= lut_x;
          if (k == SW'(NUM_ROTORS-1)) state <= S_REFL;
          else                        k     <= k + 1'b1;
        end
        S_REFL: begin
          x     <= refl_x;
          k     <= SW'(NUM_ROTORS-1);
          state <= S_BWD;
        end
        S_BWD: begin
          x <= lut_x;
          if (k == '0) begin
            dout_q <= 8'(plug_map(lut_x)) + ASCII_A;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else k <= k - 1'b1;
        end
        S_DONE: begin
          dout_q <= '0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_core.sv
// Directed bench for enigma_core: cipher vectors, odometer carry, bypass, abort, stall, reset.
module tb_enigma_core;
  localparam int N  = 3;
  localparam int A  = 26;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic reset_n, set, en;
  logic [N*IW-1:0]   pos_in, pos_out;
  logic [N*A*IW-1:0] wiring_in;
  logic [A*IW-1:0]   refl_in;
`ifdef ENIGMA_PLUGBOARD_EN
  logic [A*IW-1:0]   plug_in;
`endif

  enigma_if bus();

  enigma_core #(.NUM_ROTORS(N), .ALPHA(A), .IW(IW)) dut (
    .clk(clk), .reset_n(reset_n), .set(set), .en(en),
    .pos_in(pos_in), .wiring_in(wiring_in), .refl_in(refl_in),
`ifdef ENIGMA_PLUGBOARD_EN
    .plug_in(plug_in),
`endif
    .pos_out(pos_out), .io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [N*IW-1:0] pos3(input int p0, input int p1, input int p2);
    return {IW'(p2), IW'(p1), IW'(p0)};
  endfunction

  task automatic do_set(input logic [N*IW-1:0] p);
    set = 1'b1; pos_in = p;
    @(negedge clk);
    set = 1'b0;
  endtask

  // Accepts one byte and counts edges until done; en is dropped for stall_len edges after edge stall_at.
  task automatic run_char(input logic [7:0] c, input int stall_at, input int stall_len,
                          output int n, output logic [7:0] d);
    chk($sformatf("ready_before_%02h", c), 32'(bus.ready), 32'd1);
    bus.valid = 1'b1; bus.din = c;
    @(negedge clk);
    bus.valid = 1'b0;
    n = 1;
    while (!bus.done && n < 60) begin
      if (n == stall_at) en = 1'b0;
      if (n == stall_at + stall_len) en = 1'b1;
      @(negedge clk);
      n++;
    end
    en = 1'b1;
    d  = bus.dout;
  endtask

  initial begin
    string rot [3];
    string s, pt, ct;
    int n;
    logic [7:0] d;
    logic saw;

    rot[0] = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    rot[1] = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    rot[2] = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    wiring_in = '0; refl_in = '0;
    for (int k = 0; k < N; k++) begin
      s = rot[k];
      for (int j = 0; j < A; j++) wiring_in[(k*A+j)*IW +: IW] = IW'(s[j] - 8'h41);
    end
    s = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    for (int j = 0; j < A; j++) refl_in[j*IW +: IW] = IW'(s[j] - 8'h41);
`ifdef ENIGMA_PLUGBOARD_EN
    for (int j = 0; j < A; j++) plug_in[j*IW +: IW] = IW'(j);
`endif

    reset_n = 1'b0; set = 1'b0; en = 1'b1; pos_in = '0;
    bus.valid = 1'b0; bus.din = 8'h00;
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_dout",  32'(bus.dout),  32'd0);
    chk("rst_pos",   32'(pos_out),   32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.ready), 32'd1);

    // Encrypt then decrypt from the same start positions
    pt = "AAAAA"; ct = "BDZGO";
    do_set(pos3(0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      run_char(pt[i], 0, 0, n, d);
      chk($sformatf("enc_lat_%0d", i),  32'(n), 32'd9);
      chk($sformatf("enc_dout_%0d", i), 32'(d), 32'(ct[i]));
      @(negedge clk);
      chk($sformatf("enc_pulse_%0d", i), 32'(bus.done), 32'd0);
    end
    chk("enc_pos", 32'(pos_out), 32'(pos3(5, 0, 0)));

    do_set(pos3(0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      run_char(ct[i], 0, 0, n, d);
      chk($sformatf("dec_dout_%0d", i), 32'(d), 32'(pt[i]));
      @(negedge clk);
    end

    // Odometer carry ripple and discarded final carry
    do_set(pos3(25, 25, 0));
    run_char("A", 0, 0, n, d);
    chk("carry_pos", 32'(pos_out), 32'(pos3(0, 0, 1)));
    @(negedge clk);
    do_set(pos3(25, 25, 25));
    run_char("A", 0, 0, n, d);
    chk("wrap_pos", 32'(pos_out), 32'(pos3(0, 0, 0)));
    @(negedge clk);

    // Non-letter bypass
    do_set(pos3(7, 3, 1));
    run_char(8'h20, 0, 0, n, d);
    chk("bypass_sp_lat",  32'(n), 32'd1);
    chk("bypass_sp_dout", 32'(d), 32'h20);
    chk("bypass_sp_pos",  32'(pos_out), 32'(pos3(7, 3, 1)));
    @(negedge clk);
    chk("bypass_sp_pulse", 32'(bus.done), 32'd0);
    run_char(8'h61, 0, 0, n, d);
    chk("bypass_lc_lat",  32'(n), 32'd1);
    chk("bypass_lc_dout", 32'(d), 32'h61);
    chk("bypass_lc_pos",  32'(pos_out), 32'(pos3(7, 3, 1)));
    @(negedge clk);

    // Abort with set while in the first forward stage
    do_set(pos3(0, 0, 0));
    bus.valid = 1'b1; bus.din = "A";
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    set = 1'b1; pos_in = pos3(3, 2, 1);
    @(negedge clk);
    set = 1'b0;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_pos",   32'(pos_out),   32'(pos3(3, 2, 1)));
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) saw = 1'b1;
      @(negedge clk);
    end
    chk("abort_nodone", 32'(saw), 32'd0);

    // Stall with en low for four edges, then freeze while in DONE
    do_set(pos3(0, 0, 0));
    run_char("A", 3, 4, n, d);
    chk("stall_lat",  32'(n), 32'd13);
    chk("stall_dout", 32'(d), 32'h42);
    en = 1'b0;
    @(negedge clk);
    chk("freeze_done", 32'(bus.done), 32'd1);
    chk("freeze_dout", 32'(bus.dout), 32'h42);
    chk("freeze_ready", 32'(bus.ready), 32'd0);
    en = 1'b1;
    @(negedge clk);
    chk("freeze_release", 32'(bus.done), 32'd0);

    // Asynchronous reset while the result is presented
    do_set(pos3(0, 0, 0));
    run_char("A", 0, 0, n, d);
    chk("pre_rst_done", 32'(bus.done), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_done", 32'(bus.done), 32'd0);
    chk("async_rst_dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_pos",   32'(pos_out),   32'd0);
    chk("post_rst_ready", 32'(bus.ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
